// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the pipeline stage register.
// The state encoding equals the number of held entries, so occupancy
// can be read straight from the state register.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Number of held entries represented by a control state.
    function automatic logic [OCC_W-1:0] state_occ(input state_t s);
        case (s)
            ST_EMPTY: return 2'd0;
            ST_ONE:   return 2'd1;
            ST_FULL:  return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data stream bundle used on both sides of a pipeline stage.
// The producer uses the master modport, the consumer the slave modport.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_entry.sv
// One payload register of a pipeline stage: async reset, synchronous
// clear (used for flush) with priority over load.
module pipe_entry #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_r;

    // Payload storage: clear wins over load so a flushed entry never keeps stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            data_r <= {DATA_W{1'b0}};
        end else if (load) begin
            data_r <= d;
        end else begin
            data_r <= data_r;
        end
    end

    assign q = data_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and flush.
// SKID=0: one entry, in_ready is combinational (out_ready | ~out_valid).
// SKID=1: main + skid entry, in_ready comes from a flop so stall paths
// do not chain across stages. out_data is always the main entry register.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int SKID   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [OCC_W-1:0]     occupancy,
    output logic [OCC_W-1:0]     flush_drop
);

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              in_ready_s;
    logic              out_valid_s;
    logic              main_load_s;
    logic [DATA_W-1:0] main_d_s;
    logic [DATA_W-1:0] main_q_s;
    logic [OCC_W-1:0]  occ_s;
    logic [OCC_W-1:0]  drop_r;

    assign in_xfer_s  = up.valid & in_ready_s;
    assign out_xfer_s = out_valid_s & dn.ready;

    assign up.ready   = in_ready_s;
    assign dn.valid   = out_valid_s;
    assign dn.data    = main_q_s;
    assign occupancy  = occ_s;
    assign flush_drop = drop_r;

    pipe_entry #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load_s),
        .clear (flush),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    // Count of entries killed by a flush; an entry leaving in the flush cycle was delivered, not killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_r <= {OCC_W{1'b0}};
        end else if (flush) begin
            drop_r <= occ_s - OCC_W'(out_xfer_s);
        end else begin
            drop_r <= {OCC_W{1'b0}};
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            state_t            state_r;
            state_t            state_nxt_s;
            logic              ready_r;
            logic              skid_load_s;
            logic              sel_skid_s;
            logic [DATA_W-1:0] skid_q_s;

            pipe_entry #(.DATA_W(DATA_W)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load_s),
                .clear (flush),
                .d     (up.data),
                .q     (skid_q_s)
            );

            // State register plus registered in_ready, precomputed from the next state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_r <= ST_EMPTY;
                    ready_r <= 1'b1;
                end else begin
                    state_r <= state_nxt_s;
                    ready_r <= (state_nxt_s != ST_FULL);
                end
            end

            // Next state and entry load controls; flush overrides every transition.
            always_comb begin
                state_nxt_s = state_r;
                main_load_s = 1'b0;
                skid_load_s = 1'b0;
                sel_skid_s  = 1'b0;
                if (flush) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    case (state_r)
                        ST_EMPTY: begin
                            if (in_xfer_s) begin
                                state_nxt_s = ST_ONE;
                                main_load_s = 1'b1;
                            end else begin
                                state_nxt_s = ST_EMPTY;
                            end
                        end
                        ST_ONE: begin
                            if (in_xfer_s && out_xfer_s) begin
                                state_nxt_s = ST_ONE;
                                main_load_s = 1'b1;
                            end else if (in_xfer_s) begin
                                state_nxt_s = ST_FULL;
                                skid_load_s = 1'b1;
                            end else if (out_xfer_s) begin
                                state_nxt_s = ST_EMPTY;
                            end else begin
                                state_nxt_s = ST_ONE;
                            end
                        end
                        ST_FULL: begin
                            if (out_xfer_s) begin
                                state_nxt_s = ST_ONE;
                                main_load_s = 1'b1;
                                sel_skid_s  = 1'b1;
                            end else begin
                                state_nxt_s = ST_FULL;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_EMPTY;
                        end
                    endcase
                end
            end

            assign in_ready_s  = ready_r;
            assign out_valid_s = (state_r != ST_EMPTY);
            assign occ_s       = state_occ(state_r);
            assign main_d_s    = sel_skid_s ? skid_q_s : up.data;
        end else begin : g_single
            logic valid_r;

            // Main entry valid flag; a simultaneous pop and push keeps it set (no bubble).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_r <= 1'b0;
                end else if (flush) begin
                    valid_r <= 1'b0;
                end else if (in_xfer_s) begin
                    valid_r <= 1'b1;
                end else if (out_xfer_s) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end

            assign in_ready_s  = dn.ready | ~valid_r;
            assign out_valid_s = valid_r;
            assign occ_s       = {1'b0, valid_r};
            assign main_d_s    = up.data;
            assign main_load_s = in_xfer_s & ~flush;
        end
    endgenerate

endmodule
